// File: rtl/c8_rom_arbiter.sv
// c8_rom_arbiter
// Single owner of the shared $C800-$CFFF expansion-ROM window for all slot
// cards. A slot claims the window by accessing its $Cn00-$CnFF I/O select
// space. An access to $CFFF releases it. With SLOTC3ROM clear, an access to
// $C3xx hands the window to the internal ROM. Ownership is re-evaluated once
// per bus cycle, at the falling edge of phi0 as seen in the clk_logic domain.
//
// Optional feature: define C8_ARB_STATS_EN to build a saturating claim counter.
// When the macro is undefined, claim_count_o is tied to zero.
//
// Ports
//   clk_logic       system logic clock
//   system_reset_n  asynchronous active-low reset
//   phi0            bus phase 0; a bus cycle is valid while high
//   addr, rw_n      bus address and direction (1 = read)
//   intcxrom        1 = internal ROM mapped over $C100-$CFFF (freezes ownership)
//   slotc3rom       0 = $C3xx is internal
//   card_rd_en_i    per-slot read-drive request (bit i = slot i+1)
//   card_data_i     per-slot read data, slot s at [8*(s-1)+:8]
//   c8_en_o         one-hot per-slot $C800 ROM enable
//   c8_owner_o      owning slot number, 0 when none or internal
//   int_owner_o     internal ROM owns the window
//   data_o, rd_en_o merged read data and bus drive enable
//   conflict_o      sticky multiple-driver flag
//   claim_count_o   claim statistics
module c8_rom_arbiter #(
  parameter int                   NUM_SLOTS = 7,
  parameter logic [NUM_SLOTS-1:0] SLOT_MASK = 7'h7F
) (
  input  logic                   clk_logic,
  input  logic                   system_reset_n,
  input  logic                   phi0,
  input  logic [15:0]            addr,
  input  logic                   rw_n,
  input  logic                   intcxrom,
  input  logic                   slotc3rom,
  input  logic [NUM_SLOTS-1:0]   card_rd_en_i,
  input  logic [8*NUM_SLOTS-1:0] card_data_i,
  output logic [NUM_SLOTS-1:0]   c8_en_o,
  output logic [2:0]             c8_owner_o,
  output logic                   int_owner_o,
  output logic [7:0]             data_o,
  output logic                   rd_en_o,
  output logic                   conflict_o,
  output logic [15:0]            claim_count_o
);

  typedef enum logic [1:0] {
    ST_NONE     = 2'd0,
    ST_SLOT     = 2'd1,
    ST_INTERNAL = 2'd2
  } state_t;

  // Bit n set = slot n present, indexed directly by addr[11:8].
  localparam logic [15:0] SLOT_PRESENT = 16'({SLOT_MASK, 1'b0});

  state_t     state_reg, state_next;
  logic [2:0] slot_reg, slot_next;   // held at 0 unless a slot owns the window
  logic       phi0_q_reg;
  logic       conflict_reg;
  logic       cycle_end;
  logic       slot_hit;
  logic       window_access;
  logic [7:0] data_sel;

  assign cycle_end     = phi0_q_reg & ~phi0;
  assign slot_hit      = (addr[15:12] == 4'hC) & SLOT_PRESENT[addr[11:8]];
  assign window_access = phi0 & ~intcxrom & (addr[15:11] == 5'b11001);

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_reg    <= ST_NONE;
      slot_reg     <= 3'd0;
      phi0_q_reg   <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      slot_reg   <= slot_next;
      phi0_q_reg <= phi0;
      if (rw_n && phi0 && ($countones(card_rd_en_i) > 1))
        conflict_reg <= 1'b1;
    end
  end

  // Ownership rules in priority order; INTCXROM freezes the current owner.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    if (cycle_end && !intcxrom) begin
      if (addr == 16'hCFFF) begin
        state_next = ST_NONE;
        slot_next  = 3'd0;
      end else if ((addr[15:8] == 8'hC3) && !slotc3rom) begin
        state_next = ST_INTERNAL;
        slot_next  = 3'd0;
      end else if (slot_hit) begin
        state_next = ST_SLOT;
        slot_next  = addr[10:8];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_c8_en
      assign c8_en_o[gi] = (state_reg == ST_SLOT) && (slot_reg == 3'(gi + 1)) && window_access;
    end
  endgenerate

  // Lowest-numbered requesting slot wins; scan from the top so it is written last.
  always_comb begin
    data_sel = 8'hFF;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (card_rd_en_i[i])
        data_sel = card_data_i[8*i +: 8];
    end
  end

  assign data_o      = system_reset_n ? data_sel : 8'h00;
  assign rd_en_o     = system_reset_n & rw_n & (|card_rd_en_i);
  assign c8_owner_o  = slot_reg;
  assign int_owner_o = (state_reg == ST_INTERNAL);
  assign conflict_o  = conflict_reg;

`ifdef C8_ARB_STATS_EN
  logic [15:0] claim_cnt_reg;
  logic        claim_event;

  // Only a change of owner counts; a slot re-claiming its own window does not.
  assign claim_event = cycle_end && (state_next != ST_NONE) &&
                       ((state_next != state_reg) || (slot_next != slot_reg));

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n)
      claim_cnt_reg <= 16'h0000;
    else if (claim_event && (claim_cnt_reg != 16'hFFFF))
      claim_cnt_reg <= claim_cnt_reg + 16'd1;
  end

  assign claim_count_o = claim_cnt_reg;
`else
  assign claim_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_c8_rom_arbiter.sv
// Directed bench for c8_rom_arbiter. Two instances share all inputs: A with
// every slot present, B with slot 3 absent. A bus-cycle-level ownership model
// predicts every output, checked each negedge, plus literal checks of A/B.
module tb_c8_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, phi0, rw_n, intcxrom, slotc3rom;
  logic [15:0] addr;
  logic [6:0]  card_rd_en;
  logic [55:0] card_data;

  logic [6:0]  c8_en_w    [2];
  logic [2:0]  owner_w    [2];
  logic        int_w      [2];
  logic [7:0]  data_w     [2];
  logic        rd_en_w    [2];
  logic        conflict_w [2];
  logic [15:0] count_w    [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  c8_rom_arbiter #(.NUM_SLOTS(7), .SLOT_MASK(7'h7F)) dut_a (
    .clk_logic(clk), .system_reset_n(rst_n), .phi0(phi0), .addr(addr), .rw_n(rw_n),
    .intcxrom(intcxrom), .slotc3rom(slotc3rom), .card_rd_en_i(card_rd_en),
    .card_data_i(card_data), .c8_en_o(c8_en_w[0]), .c8_owner_o(owner_w[0]),
    .int_owner_o(int_w[0]), .data_o(data_w[0]), .rd_en_o(rd_en_w[0]),
    .conflict_o(conflict_w[0]), .claim_count_o(count_w[0]));

  c8_rom_arbiter #(.NUM_SLOTS(7), .SLOT_MASK(7'h7B)) dut_b (
    .clk_logic(clk), .system_reset_n(rst_n), .phi0(phi0), .addr(addr), .rw_n(rw_n),
    .intcxrom(intcxrom), .slotc3rom(slotc3rom), .card_rd_en_i(card_rd_en),
    .card_data_i(card_data), .c8_en_o(c8_en_w[1]), .c8_owner_o(owner_w[1]),
    .int_owner_o(int_w[1]), .data_o(data_w[1]), .rd_en_o(rd_en_w[1]),
    .conflict_o(conflict_w[1]), .claim_count_o(count_w[1]));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: owner 0 = none, 1..7 = slot, 8 = internal ----------------
  int   own_m [2];
  int   cnt_m [2];
  logic conf_m;
  logic phi0_prev;

  function automatic logic [6:0] mask_of(input int k);
    return (k == 0) ? 7'h7F : 7'h7B;
  endfunction

  function automatic int next_owner(input int cur, input logic [15:0] a, input logic [6:0] mask,
                                    input logic cx, input logic c3);
    int n;
    n = int'(a[11:8]);
    if (cx) return cur;
    if (a == 16'hCFFF) return 0;
    if (a[15:8] == 8'hC3 && !c3) return 8;
    if (a[15:12] == 4'hC && n >= 1 && n <= 7 && mask[n-1]) return n;
    return cur;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_m     <= '{0, 0};
      cnt_m     <= '{0, 0};
      conf_m    <= 1'b0;
      phi0_prev <= 1'b0;
    end else begin
      phi0_prev <= phi0;
      if (rw_n && phi0 && $countones(card_rd_en) > 1) conf_m <= 1'b1;
      if (phi0_prev && !phi0) begin
        for (int k = 0; k < 2; k++) begin
          int nxt;
          nxt = next_owner(own_m[k], addr, mask_of(k), intcxrom, slotc3rom);
          if (nxt != own_m[k] && nxt != 0 && cnt_m[k] < 65535) cnt_m[k] <= cnt_m[k] + 1;
          own_m[k] <= nxt;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    logic [7:0] dexp;
    logic       rexp;
    dexp = 8'hFF;
    for (int i = 6; i >= 0; i--)
      if (card_rd_en[i]) dexp = card_data[8*i +: 8];
    rexp = rw_n & (|card_rd_en);
    if (!rst_n) begin
      dexp = 8'h00;
      rexp = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      logic [6:0] en_exp;
      en_exp = 7'd0;
      if (own_m[k] >= 1 && own_m[k] <= 7 && phi0 && !intcxrom && addr[15:11] == 5'b11001)
        en_exp[own_m[k]-1] = 1'b1;
      check($sformatf("cyc%0d_c8_en", k), 16'(c8_en_w[k]), 16'(en_exp));
      check($sformatf("cyc%0d_owner", k), 16'(owner_w[k]), (own_m[k] <= 7) ? 16'(own_m[k]) : 16'd0);
      check($sformatf("cyc%0d_int", k), 16'(int_w[k]), 16'(own_m[k] == 8));
      check($sformatf("cyc%0d_data", k), 16'(data_w[k]), 16'(dexp));
      check($sformatf("cyc%0d_rd_en", k), 16'(rd_en_w[k]), 16'(rexp));
      check($sformatf("cyc%0d_conflict", k), 16'(conflict_w[k]), 16'(conf_m));
`ifdef C8_ARB_STATS_EN
      check($sformatf("cyc%0d_count", k), count_w[k], 16'(cnt_m[k]));
`else
      check($sformatf("cyc%0d_count", k), count_w[k], 16'h0000);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_cycle(input logic [15:0] a, input logic rw);
    @(posedge clk); #2;
    addr = a; rw_n = rw; phi0 = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic end_cycle();
    phi0 = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic bus(input logic [15:0] a, input logic rw);
    start_cycle(a, rw);
    end_cycle();
    $display("[TB] bus %s $%h -> ownerA=%0d intA=%0b ownerB=%0d intB=%0b",
             rw ? "rd" : "wr", a, owner_w[0], int_w[0], owner_w[1], int_w[1]);
  endtask

  initial begin
    rst_n = 1'b0; phi0 = 1'b0; addr = 16'h0000; rw_n = 1'b1;
    intcxrom = 1'b0; slotc3rom = 1'b1;
    card_rd_en = 7'b0000001;
    card_data  = 56'h77_66_55_44_33_22_11;

    repeat (3) @(posedge clk);
    #3;
    check("reset_owner", 16'(owner_w[0]), 16'd0);
    check("reset_int", 16'(int_w[0]), 16'd0);
    check("reset_conflict", 16'(conflict_w[0]), 16'd0);
    check("reset_data", 16'(data_w[0]), 16'h00);
    check("reset_rd_en", 16'(rd_en_w[0]), 16'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    card_rd_en = 7'b0000000;

    bus(16'hC200, 1'b1);
    #1 check("claim_c200_owner", 16'(owner_w[0]), 16'd2);
    start_cycle(16'hC800, 1'b1);
    #1 check("c800_en_slot2", 16'(c8_en_w[0]), 16'h0002);
    end_cycle();

    start_cycle(16'hCFFF, 1'b1);
    #1 check("cfff_served_by_old", 16'(c8_en_w[0]), 16'h0002);
    end_cycle();
    #1 check("cfff_release_owner", 16'(owner_w[0]), 16'd0);
    start_cycle(16'hC800, 1'b1);
    #1 check("c800_after_release", 16'(c8_en_w[0]), 16'h0000);
    end_cycle();

    bus(16'hC200, 1'b1);
    bus(16'hC200, 1'b1);
    bus(16'hC500, 1'b1);
    #1 check("c500_owner", 16'(owner_w[0]), 16'd5);
    start_cycle(16'hC800, 1'b1);
    #1 check("c800_en_slot5", 16'(c8_en_w[0]), 16'h0010);
    end_cycle();

    slotc3rom = 1'b0;
    bus(16'hC300, 1'b1);
    #1 check("c3_internal_int", 16'(int_w[0]), 16'd1);
    check("c3_internal_owner", 16'(owner_w[0]), 16'd0);
    start_cycle(16'hC800, 1'b1);
    #1 check("c800_internal_en", 16'(c8_en_w[0]), 16'h0000);
    end_cycle();
    slotc3rom = 1'b1;
    bus(16'hC300, 1'b1);
    #1 check("c3_slot_owner", 16'(owner_w[0]), 16'd3);
    check("b_absent_c3_int", 16'(int_w[1]), 16'd1);
    check("b_absent_c3_owner", 16'(owner_w[1]), 16'd0);

    intcxrom = 1'b1;
    bus(16'hC600, 1'b1);
    #1 check("intcx_owner_kept", 16'(owner_w[0]), 16'd3);
    start_cycle(16'hC800, 1'b1);
    #1 check("intcx_c800_en", 16'(c8_en_w[0]), 16'h0000);
    end_cycle();
    intcxrom = 1'b0;

    card_rd_en = 7'b0010000;
    start_cycle(16'hC080, 1'b1);
    #1 check("single_req_data", 16'(data_w[0]), 16'h55);
    rw_n = 1'b0;
    #1 check("write_no_drive", 16'(rd_en_w[0]), 16'd0);
    rw_n = 1'b1;
    end_cycle();

    card_data[15:8]  = 8'hAA;
    card_data[23:16] = 8'h55;
    card_rd_en = 7'b0000110;
    start_cycle(16'hC080, 1'b1);
    #1 check("merge_data", 16'(data_w[0]), 16'h00AA);
    check("merge_rd_en", 16'(rd_en_w[0]), 16'd1);
    end_cycle();
    card_rd_en = 7'b0000000;
    #1 check("conflict_set", 16'(conflict_w[0]), 16'd1);
    bus(16'hC100, 1'b1);
    #1 check("conflict_sticky", 16'(conflict_w[0]), 16'd1);

    start_cycle(16'hC400, 1'b1);
    rst_n = 1'b0;
    #1 check("midreset_owner", 16'(owner_w[0]), 16'd0);
    check("midreset_conflict", 16'(conflict_w[0]), 16'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    end_cycle();
    #1 check("post_reset_claim", 16'(owner_w[0]), 16'd4);

    start_cycle(16'hC100, 1'b1);
    repeat (5) @(posedge clk);
    #3 check("phi0_stuck_owner", 16'(owner_w[0]), 16'd4);
    end_cycle();
    #1 check("phi0_fall_claim", 16'(owner_w[0]), 16'd1);

    bus(16'hCFFF, 1'b0);
    #1 check("cfff_write_release", 16'(owner_w[0]), 16'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
